// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost-full/empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
module param_fifo #(
    parameter int Width       = 8,
    parameter int Depth       = 8,
    parameter int AlmostFull  = Depth - 2,
    parameter int AlmostEmpty = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [Width-1:0]         cData,
    input  logic                     cPush,
    input  logic                     cPop,
    input  logic                     cFlush,
    output logic [Width-1:0]         hData,
    output logic                     hFull,
    output logic                     hEmpty,
    output logic                     hAlmostFull,
    output logic                     hAlmostEmpty,
    output logic [$clog2(Depth):0]   hCount,
    output logic                     hOverflow,
    output logic                     hUnderflow
);

    localparam int AddrW  = $clog2(Depth);
    localparam int CountW = AddrW + 1;

    localparam logic [CountW-1:0] FullLevel = CountW'(Depth);
    localparam logic [CountW-1:0] AfLevel   = CountW'(AlmostFull);
    localparam logic [CountW-1:0] AeLevel   = CountW'(AlmostEmpty);

    logic [Width-1:0]  mem [Depth];
    logic [AddrW-1:0]  rd_ptr;
    logic [AddrW-1:0]  wr_ptr;
    logic [CountW-1:0] count;

    logic full;
    logic empty;
    logic wr_en;
    logic rd_en;
    logic bypass;
    logic set_ovf;
    logic set_udf;

    assign full         = (count == FullLevel);
    assign empty        = (count == '0);
    assign hFull        = full;
    assign hEmpty       = empty;
    assign hAlmostFull  = (count >= AfLevel);
    assign hAlmostEmpty = (count <= AeLevel);
    assign hCount       = count;

    // Decode the request pair; flush suppresses everything including the error flags.
    always_comb begin
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        bypass  = 1'b0;
        set_ovf = 1'b0;
        set_udf = 1'b0;
        if (!cFlush) begin
            unique case ({cPush, cPop})
                2'b10: begin
                    if (full) set_ovf = 1'b1;
                    else      wr_en   = 1'b1;
                end
                2'b01: begin
                    if (empty) set_udf = 1'b1;
                    else       rd_en   = 1'b1;
                end
                2'b11: begin
                    if (empty) begin
                        bypass = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        rd_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // When full the read and write share a slot; the read sees the old word.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= cData;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            hData      <= '0;
            hOverflow  <= 1'b0;
            hUnderflow <= 1'b0;
        end else if (cFlush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            hOverflow  <= 1'b0;
            hUnderflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AddrW'(1);
            if (rd_en) begin
                hData  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AddrW'(1);
            end else if (bypass) begin
                hData <= cData;
            end
            if (wr_en && !rd_en)      count <= count + CountW'(1);
            else if (rd_en && !wr_en) count <= count - CountW'(1);
            if (set_ovf) hOverflow  <= 1'b1;
            if (set_udf) hUnderflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench for param_fifo: an 8x8 instance for fill/drain, errors,
// bypass, flush and async reset, and a 16x4 instance for pointer wrap-around.
module tb_param_fifo;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Instance A: Width=8, Depth=8, AlmostFull=6, AlmostEmpty=1
    logic [7:0] a_data = '0;
    logic       a_push = 1'b0;
    logic       a_pop = 1'b0;
    logic       a_flush = 1'b0;
    logic [7:0] a_hdata;
    logic       a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;
    logic [3:0] a_count;

    param_fifo #(.Width(8), .Depth(8)) dut_a (
        .clock(clock), .reset(reset),
        .cData(a_data), .cPush(a_push), .cPop(a_pop), .cFlush(a_flush),
        .hData(a_hdata), .hFull(a_full), .hEmpty(a_empty),
        .hAlmostFull(a_afull), .hAlmostEmpty(a_aempty), .hCount(a_count),
        .hOverflow(a_ovf), .hUnderflow(a_udf)
    );

    // Instance B: Width=16, Depth=4, AlmostFull=3, AlmostEmpty=1
    logic [15:0] b_data = '0;
    logic        b_push = 1'b0;
    logic        b_pop = 1'b0;
    logic        b_flush = 1'b0;
    logic [15:0] b_hdata;
    logic        b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
    logic [2:0]  b_count;

    param_fifo #(.Width(16), .Depth(4), .AlmostFull(3), .AlmostEmpty(1)) dut_b (
        .clock(clock), .reset(reset),
        .cData(b_data), .cPush(b_push), .cPop(b_pop), .cFlush(b_flush),
        .hData(b_hdata), .hFull(b_full), .hEmpty(b_empty),
        .hAlmostFull(b_afull), .hAlmostEmpty(b_aempty), .hCount(b_count),
        .hOverflow(b_ovf), .hUnderflow(b_udf)
    );

    logic [15:0] model_q[$];
    logic [15:0] next_word = 16'h1000;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic push, input logic pop, input logic flush,
                                  input logic [7:0] data);
        a_push  = push;
        a_pop   = pop;
        a_flush = flush;
        a_data  = data;
        @(posedge clock);
        #1;
        a_push  = 1'b0;
        a_pop   = 1'b0;
        a_flush = 1'b0;
    endtask

    // Status of instance A from an expected occupancy (Depth 8, AF 6, AE 1).
    task automatic check_a_status(input string tag, input int cnt);
        check_output({tag, "_count"},  32'(a_count),  32'(cnt));
        check_output({tag, "_full"},   32'(a_full),   32'(cnt == 8));
        check_output({tag, "_empty"},  32'(a_empty),  32'(cnt == 0));
        check_output({tag, "_afull"},  32'(a_afull),  32'(cnt >= 6));
        check_output({tag, "_aempty"}, 32'(a_aempty), 32'(cnt <= 1));
    endtask

    task automatic check_a_reset_values(input string tag);
        check_output({tag, "_data"}, 32'(a_hdata), 32'h0);
        check_a_status(tag, 0);
        check_output({tag, "_ovf"}, 32'(a_ovf), 32'h0);
        check_output({tag, "_udf"}, 32'(a_udf), 32'h0);
    endtask

    // One cycle on instance B with a queue reference model (no overflow/underflow use).
    task automatic b_step(input logic push, input logic pop);
        logic [15:0] exp_data;
        logic        has_exp;
        has_exp = 1'b0;
        exp_data = '0;
        b_push = push;
        b_pop  = pop;
        b_data = next_word;
        if (push && pop && model_q.size() == 0) begin
            exp_data = next_word;
            has_exp  = 1'b1;
        end else begin
            if (pop && model_q.size() > 0) begin
                exp_data = model_q.pop_front();
                has_exp  = 1'b1;
            end
            if (push && model_q.size() < 4) model_q.push_back(next_word);
        end
        if (push) next_word = next_word + 16'h1;
        @(posedge clock);
        #1;
        b_push = 1'b0;
        b_pop  = 1'b0;
        if (has_exp) check_output("b_data", 32'(b_hdata), 32'(exp_data));
        check_output("b_count",  32'(b_count),  32'(model_q.size()));
        check_output("b_full",   32'(b_full),   32'(model_q.size() == 4));
        check_output("b_empty",  32'(b_empty),  32'(model_q.size() == 0));
        check_output("b_afull",  32'(b_afull),  32'(model_q.size() >= 3));
        check_output("b_aempty", 32'(b_aempty), 32'(model_q.size() <= 1));
        check_output("b_ovf",    32'(b_ovf),    32'h0);
    endtask

    initial begin
        #2;
        check_a_reset_values("por");
        #8;
        reset = 1'b1;

        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 8'(i));
            check_a_status("fill", i);
        end

        apply_stimulus(1'b1, 1'b0, 1'b0, 8'hAA);
        check_output("ovf_set", 32'(a_ovf), 32'h1);
        check_a_status("ovf", 8);

        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
            check_output("drain_data", 32'(a_hdata), 32'(i));
            check_a_status("drain", 8 - i);
        end

        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
        check_output("udf_set", 32'(a_udf), 32'h1);
        check_output("udf_data_hold", 32'(a_hdata), 32'h08);
        check_output("ovf_sticky", 32'(a_ovf), 32'h1);

        apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
        check_output("flush_ovf", 32'(a_ovf), 32'h0);
        check_output("flush_udf", 32'(a_udf), 32'h0);
        check_output("flush_data_hold", 32'(a_hdata), 32'h08);
        check_a_status("flush", 0);

        apply_stimulus(1'b1, 1'b1, 1'b0, 8'h5A);
        check_output("bypass_data", 32'(a_hdata), 32'h5A);
        check_a_status("bypass", 0);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
        end
        check_a_status("refill", 8);

        apply_stimulus(1'b1, 1'b1, 1'b0, 8'h77);
        check_output("fullpp_data", 32'(a_hdata), 32'h10);
        check_output("fullpp_ovf", 32'(a_ovf), 32'h0);
        check_a_status("fullpp", 8);

        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
            check_output("fullpp_drain", 32'(a_hdata), (i == 8) ? 32'h77 : 32'(8'h10 + i));
        end
        check_a_status("fullpp_end", 0);

        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h33);
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'h44);
        check_output("flushpp_ovf", 32'(a_ovf), 32'h0);
        check_output("flushpp_udf", 32'(a_udf), 32'h0);
        check_output("flushpp_data", 32'(a_hdata), 32'h77);
        check_a_status("flushpp", 0);

        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
        check_output("post_flush_udf", 32'(a_udf), 32'h1);
        check_output("post_flush_data", 32'(a_hdata), 32'h77);

        for (int i = 1; i <= 5; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        end
        check_a_status("pre_reset", 5);

        #2;
        reset = 1'b0;
        #1;
        check_a_reset_values("async_rst");
        reset = 1'b1;

        apply_stimulus(1'b1, 1'b1, 1'b0, 8'h99);
        check_output("rst_bypass_data", 32'(a_hdata), 32'h99);
        check_a_status("rst_bypass", 0);

        b_step(1'b1, 1'b0);
        b_step(1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            b_step((k % 4) < 2, (k % 4) >= 2);
        end
        for (int k = 0; k < 3; k++) begin
            b_step(1'b0, 1'b1);
        end
        b_step(1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
